// File: rtl/out_fifo_drain.sv
// out_fifo_drain: drains the PHY output FIFO into a primed skid buffer feeding a valid/ready stream
module out_fifo_drain #(
    parameter int Q_WIDTH     = 48,
    parameter int RD_LATENCY  = 1,
    parameter int BUF_DEPTH   = 4,
    parameter int PRIME_LEVEL = 2
) (
    input  logic               RDCLK,
    input  logic               RESET,
    input  logic               EMPTY,
    input  logic               ALMOSTEMPTY,
    input  logic [Q_WIDTH-1:0] Q,
    output logic               RDEN,
    input  logic               enable,
    output logic [Q_WIDTH-1:0] m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               underrun,
    output logic               busy,
    output logic [15:0]        rd_count
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(BUF_DEPTH);
    localparam logic [CW-1:0] PRIME_C = CW'(PRIME_LEVEL);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FILL   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;
    localparam logic [1:0] DRAIN  = 2'd3;

    logic [1:0]            state, state_nx;
    logic [Q_WIDTH-1:0]    buf_mem [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         occ, inflight;
    logic [CW:0]           credit;
    logic [RD_LATENCY-1:0] pipe;
    logic                  issued_last, underrun_q, push, pop, starve;

    // count reads still travelling through the FIFO read latency
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(pipe[i]);
    end

    assign credit   = {1'b0, occ} + {1'b0, inflight};
    assign RDEN     = (state == FILL || state == STREAM) && !EMPTY && credit < DEPTH_C
                      && !(ALMOSTEMPTY && issued_last);
    assign push     = pipe[RD_LATENCY-1];
    assign m_valid  = (state == STREAM || state == DRAIN) && occ != '0;
    assign pop      = m_valid && m_ready;
    assign m_data   = buf_mem[rd_ptr];
    assign starve   = state == STREAM && enable && m_ready && occ == '0;
    assign underrun = underrun_q || starve;
    assign busy     = state != IDLE;

    // prime, stream, re-prime on starvation, drain on disable
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = enable ? FILL : IDLE;
            FILL:    state_nx = !enable ? DRAIN : (occ >= PRIME_C) ? STREAM : FILL;
            STREAM:  state_nx = !enable ? DRAIN : starve ? FILL : STREAM;
            default: state_nx = (occ == '0 && inflight == '0) ? IDLE : DRAIN;
        endcase
    end

    // control state, pointers, occupancy and latency pipe
    always_ff @(posedge RDCLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            pipe        <= '0;
            issued_last <= 1'b0;
            underrun_q  <= 1'b0;
            rd_count    <= '0;
        end else begin
            state       <= state_nx;
            pipe        <= RD_LATENCY'({pipe, RDEN});
            issued_last <= RDEN;
            occ         <= occ + CW'(push) - CW'(pop);
            if (starve) underrun_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (pop) rd_count <= rd_count + 16'd1;
        end
    end

    // skid buffer storage, written when a read's data arrives
    always_ff @(posedge RDCLK or negedge RESET) begin
        if (!RESET) for (int i = 0; i < BUF_DEPTH; i++) buf_mem[i] <= '0;
        else if (push) buf_mem[wr_ptr] <= Q;
    end

    // credit keeps the buffer from overflowing and reads never hit an empty FIFO
    a_credit: assert property (@(posedge RDCLK) disable iff (!RESET) credit <= DEPTH_C);
    a_no_empty_read: assert property (@(posedge RDCLK) disable iff (!RESET) !(RDEN && EMPTY));
endmodule

// File: tb/tb_out_fifo_drain.sv
// tb_out_fifo_drain: directed self-checking bench for out_fifo_drain
module tb_out_fifo_drain;
    logic        RDCLK, RESET, EMPTY, ALMOSTEMPTY, RDEN, enable, m_valid, m_ready, underrun, busy;
    logic [47:0] Q = '0;
    logic [47:0] m_data, first;
    logic [15:0] rd_count;
    logic        ae;
    int          fifo_rd = 0;
    int          fifo_wr, total, bad;

    out_fifo_drain #(.Q_WIDTH(48), .RD_LATENCY(1), .BUF_DEPTH(4), .PRIME_LEVEL(2)) dut (
        .RDCLK(RDCLK), .RESET(RESET), .EMPTY(EMPTY), .ALMOSTEMPTY(ALMOSTEMPTY), .Q(Q),
        .RDEN(RDEN), .enable(enable), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .underrun(underrun), .busy(busy), .rd_count(rd_count)
    );

    assign EMPTY       = (fifo_rd == fifo_wr);
    assign ALMOSTEMPTY = ae;

    initial begin
        RDCLK = 1'b0;
        forever #5 RDCLK = ~RDCLK;
    end

    // FIFO model: word n (1-based) appears on Q one edge after its read
    always @(posedge RDCLK) begin
        if (RDEN) begin
            Q       <= 48'(fifo_rd + 1);
            fifo_rd <= fifo_rd + 1;
        end
    end

    task automatic apply_reset();
        RESET = 1'b0; enable = 1'b0; m_ready = 1'b0; ae = 1'b0;
        @(negedge RDCLK);
        fifo_wr = fifo_rd;
        @(negedge RDCLK);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        RESET = 1'b0; enable = 1'b1; m_ready = 1'b1; ae = 1'b0;
        fifo_wr = fifo_rd + 3;
        @(negedge RDCLK);
        @(negedge RDCLK);
        total++; if (RDEN !== 1'b0) begin bad++; $display("FAIL reset_rden: got %b want 0", RDEN); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        total++; if (m_data !== 48'h0) begin bad++; $display("FAIL reset_data: got %h want 0", m_data); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun: got %b want 0", underrun); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (rd_count !== 16'h0) begin bad++; $display("FAIL reset_count: got %h want 0", rd_count); end
        enable = 1'b0; m_ready = 1'b0;
        fifo_wr = fifo_rd;
        RESET = 1'b1;
    endtask

    task automatic test_prime();
        int start;
        start = fifo_rd;
        first = 48'(fifo_rd + 1);
        fifo_wr = fifo_rd + 5; enable = 1'b1; m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge RDCLK);
            if (i <= 5) begin
                total++;
                if (m_valid !== (i == 5)) begin
                    bad++; $display("FAIL prime_valid cyc%0d: got %b want %b", i, m_valid, i == 5);
                end
            end
        end
        total++; if (fifo_rd - start !== 4) begin bad++; $display("FAIL prime_reads: got %0d want 4", fifo_rd - start); end
        total++; if (RDEN !== 1'b0) begin bad++; $display("FAIL prime_rden_full: got %b want 0", RDEN); end
        total++; if (m_data !== first) begin bad++; $display("FAIL prime_data: got %h want %h", m_data, first); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL prime_busy: got %b want 1", busy); end
    endtask

    task automatic test_stream();
        fifo_wr = fifo_wr + 100; m_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== first + 48'(k) || rd_count !== 16'(k)) begin
                bad++;
                $display("FAIL stream_word%0d: got valid=%b data=%h count=%0d want valid=1 data=%h count=%0d",
                         k, m_valid, m_data, rd_count, first + 48'(k), k);
            end
            @(negedge RDCLK);
        end
        m_ready = 1'b0;
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL stream_underrun: got %b want 0", underrun); end
    endtask

    task automatic test_almost_empty();
        int   start;
        logic prev;
        apply_reset();
        start = fifo_rd;
        first = 48'(fifo_rd + 1);
        fifo_wr = fifo_rd + 4; ae = 1'b1; enable = 1'b1; m_ready = 1'b0; prev = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge RDCLK);
            total++;
            if ((RDEN && prev) || (RDEN && EMPTY)) begin
                bad++; $display("FAIL ae_rden cyc%0d: got rden=%b prev=%b empty=%b want no back-to-back and none when empty",
                                i, RDEN, prev, EMPTY);
            end
            prev = RDEN;
        end
        total++; if (fifo_rd - start !== 4) begin bad++; $display("FAIL ae_reads: got %0d want 4", fifo_rd - start); end
        total++; if (RDEN !== 1'b0) begin bad++; $display("FAIL ae_empty_rden: got %b want 0", RDEN); end
        total++; if (m_valid !== 1'b1 || m_data !== first) begin
            bad++; $display("FAIL ae_head: got valid=%b data=%h want valid=1 data=%h", m_valid, m_data, first);
        end
    endtask

    task automatic test_starvation();
        ae = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge RDCLK);
            total++;
            if (m_valid !== 1'b1 || m_data !== first + 48'(i)) begin
                bad++; $display("FAIL starve_word%0d: got valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, first + 48'(i));
            end
        end
        @(negedge RDCLK);
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL starve_valid_empty: got %b want 0", m_valid); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL starve_underrun_now: got %b want 1", underrun); end
        total++; if (RDEN !== 1'b0) begin bad++; $display("FAIL starve_rden_empty: got %b want 0", RDEN); end
        @(negedge RDCLK);
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL starve_underrun_sticky: got %b want 1", underrun); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL starve_busy: got %b want 1", busy); end
        total++; if (RDEN !== 1'b0) begin bad++; $display("FAIL starve_fill_rden_empty: got %b want 0", RDEN); end
        fifo_wr = fifo_wr + 3;
        for (int i = 6; i <= 8; i++) begin
            @(negedge RDCLK);
            total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reprime_valid cyc%0d: got %b want 0", i, m_valid); end
        end
        @(negedge RDCLK);
        total++;
        if (m_valid !== 1'b1 || m_data !== first + 48'd4) begin
            bad++; $display("FAIL reprime_head: got valid=%b data=%h want valid=1 data=%h", m_valid, m_data, first + 48'd4);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_drain();
        int start;
        apply_reset();
        start = fifo_rd;
        first = 48'(fifo_rd + 1);
        fifo_wr = fifo_rd + 10; enable = 1'b1; m_ready = 1'b0;
        repeat (3) @(negedge RDCLK);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge RDCLK);
            total++; if (RDEN !== 1'b0) begin bad++; $display("FAIL drain_rden cyc%0d: got %b want 0", i, RDEN); end
            total++;
            if (i < 3 && (m_valid !== 1'b1 || m_data !== first + 48'(i))) begin
                bad++; $display("FAIL drain_word%0d: got valid=%b data=%h want valid=1 data=%h", i, m_valid, m_data, first + 48'(i));
            end else if (i >= 3 && m_valid !== 1'b0) begin
                bad++; $display("FAIL drain_done_valid cyc%0d: got %b want 0", i, m_valid);
            end
            total++; if (busy !== (i < 4)) begin bad++; $display("FAIL drain_busy cyc%0d: got %b want %b", i, busy, i < 4); end
            m_ready = 1'b1;
        end
        m_ready = 1'b0;
        total++; if (fifo_rd - start !== 3) begin bad++; $display("FAIL drain_reads: got %0d want 3", fifo_rd - start); end
        total++; if (rd_count !== 16'd3) begin bad++; $display("FAIL drain_count: got %0d want 3", rd_count); end
    endtask

    task automatic test_reset_mid();
        fifo_wr = fifo_rd + 10; enable = 1'b1; m_ready = 1'b0;
        repeat (5) @(negedge RDCLK);
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", m_valid); end
        total++; if (rd_count !== 16'd3) begin bad++; $display("FAIL mid_pre_count: got %0d want 3", rd_count); end
        #1 RESET = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", m_valid); end
        total++; if (rd_count !== 16'h0) begin bad++; $display("FAIL mid_count: got %0d want 0", rd_count); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if (RDEN !== 1'b0) begin bad++; $display("FAIL mid_rden: got %b want 0", RDEN); end
        total++; if (m_data !== 48'h0) begin bad++; $display("FAIL mid_data: got %h want 0", m_data); end
        enable = 1'b0;
        @(negedge RDCLK);
        fifo_wr = fifo_rd;
        RESET = 1'b1;
    endtask

    task automatic test_wrap();
        int n;
        apply_reset();
        first = 48'(fifo_rd + 1);
        fifo_wr = fifo_rd + 70000; enable = 1'b1; m_ready = 1'b1; n = 0;
        for (int c = 0; c < 80000 && n < 65535; c++) begin
            @(negedge RDCLK);
            if (m_valid && m_ready) n++;
        end
        @(negedge RDCLK);
        m_ready = 1'b0;
        total++; if (n !== 65535) begin bad++; $display("FAIL wrap_budget: got %0d transfers want 65535", n); end
        total++; if (rd_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre_count: got %h want ffff", rd_count); end
        total++;
        if (m_valid !== 1'b1 || m_data !== first + 48'd65535) begin
            bad++; $display("FAIL wrap_head: got valid=%b data=%h want valid=1 data=%h", m_valid, m_data, first + 48'd65535);
        end
        m_ready = 1'b1;
        @(negedge RDCLK);
        m_ready = 1'b0;
        total++; if (rd_count !== 16'h0000) begin bad++; $display("FAIL wrap_count: got %h want 0000", rd_count); end
    endtask

    initial begin
        total = 0; bad = 0; fifo_wr = 0;
        RESET = 1'b0; enable = 1'b0; m_ready = 1'b0; ae = 1'b0;
        test_reset();
        test_prime();
        test_stream();
        test_almost_empty();
        test_starvation();
        test_drain();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/out_fifo_drain.md
Name: out_fifo_drain

Overview:
- Read-side controller that sits directly downstream of the PHY output FIFO, in the RDCLK domain.
- Watches EMPTY/ALMOSTEMPTY, generates RDEN and captures the flattened Q lanes into a small credit-managed skid buffer.
- Presents words to the serializer/phaser stage on a valid/ready handshake.
- Primes before streaming to avoid start-of-burst bubbles and flags underruns.

Parameters:
- Q_WIDTH, 48, flattened FIFO output width (Q0-Q4, Q7-Q9 at 4b plus Q5, Q6 at 8b).
- RD_LATENCY, 1, RDCLK edges from read issue to valid Q; legal 1..2.
- BUF_DEPTH, 4, skid buffer entries; power of two, must be >= RD_LATENCY+2.
- PRIME_LEVEL, 2, words buffered before m_valid first asserts; 1..BUF_DEPTH.

Ports:
- RDCLK  in  1  read clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-low reset.
- EMPTY  in  1  FIFO empty flag.
- ALMOSTEMPTY  in  1  FIFO almost-empty flag.
- Q  in  Q_WIDTH  FIFO read data.
- RDEN  out  1  FIFO read enable.
- enable  in  1  run request from the calibration/sequencer logic.
- m_data  out  Q_WIDTH  word to downstream.
- m_valid  out  1  m_data valid.
- m_ready  in  1  downstream accepts.
- underrun  out  1  sticky: downstream starved while streaming.
- busy  out  1  state != IDLE.
- rd_count  out  16  words delivered (m_valid & m_ready), wraps at 0xFFFF -> 0.

Behaviour:
- Reset (RESET=0, async): state IDLE; RDEN=0, m_valid=0, m_data=0, underrun=0, busy=0, rd_count=0.
  - Buffer pointers, occupancy and in-flight shift register are cleared.
  - Reset mid-operation drops buffered and in-flight words; the FIFO is reset alongside.
  - Deassertion takes effect on the next RDCLK edge.
- Read issue:
  - RDEN is combinational: state in {FILL, STREAM} & !EMPTY & (occ + inflight < BUF_DEPTH) & !(ALMOSTEMPTY & issued_last_cycle).
  - A read issues at an edge where RDEN=1.
  - issued_last_cycle is registered. The ALMOSTEMPTY rule forbids back-to-back reads near empty, because EMPTY lags by one cycle.
- Capture:
  - An issue flag shifts through RD_LATENCY stages.
  - When the flag exits, Q is written at wr_ptr. wr_ptr increments and wraps mod BUF_DEPTH.
  - inflight = number of set flags in the pipeline.
- Output:
  - m_data = buf[rd_ptr] (first-word fall-through from the buffer).
  - A pop occurs when m_valid & m_ready; it advances rd_ptr and increments rd_count.
  - A push and a pop at the same edge leave occ unchanged.
  - m_data and m_valid are held stable while m_valid=1 and m_ready=0.
- FSM:
  - IDLE: m_valid=0, no reads. If enable=1, go to FILL.
  - FILL: reads issue; m_valid=0.
    - When occ >= PRIME_LEVEL, go to STREAM.
    - If enable=0, go to DRAIN.
  - STREAM: m_valid = (occ > 0).
    - If m_ready=1 & occ=0 & enable=1: set underrun and go to FILL (re-prime).
    - If enable=0, go to DRAIN.
  - DRAIN: no new reads; m_valid = (occ > 0).
    - In-flight words still land and are delivered.
    - When occ=0 & inflight=0, go to IDLE.
    - enable re-asserting in DRAIN takes effect only after IDLE is reached.
- Invariants (simulation assertions):
  - occ + inflight <= BUF_DEPTH always; overflow is unreachable by credit.
  - RDEN=1 never occurs while EMPTY=1.
- underrun clears only on reset.
- busy=1 in FILL, STREAM and DRAIN.

Test Plan:
- Prime: reset, enable=1, FIFO holds 5 words, m_ready=0 -> RDEN stops at 4 issued words; m_valid rises only after the 2nd word lands; occ=4.
- Stream: m_ready=1 continuously, FIFO keeps EMPTY=0 -> one word per cycle in order (0x1, 0x2, ...); rd_count increments each cycle; underrun=0.
- Almost-empty: ALMOSTEMPTY=1, EMPTY=0 -> RDEN is never high on two consecutive cycles; no RDEN while EMPTY=1.
- Starvation: STREAM with m_ready=1, FIFO goes EMPTY and the buffer drains -> underrun=1 on the occ=0 cycle; FSM re-enters FILL; m_valid stays low until 2 words are buffered.
- Drain: enable dropped with 1 word in flight and 2 buffered -> no further RDEN; exactly 3 words delivered; then busy=0 and state IDLE.
- Reset mid-stream, plus wrap: assert RESET with occ=3 -> m_valid=0 immediately and rd_count=0; separately, preload rd_count to 0xFFFF with one transfer -> count becomes 0x0000.
